serial_symbol_aligner: RTL and testbench
========================================

// Module: serial_symbol_aligner
// PURPOSE
//  Receive-side partner of the 10-bit parallel-to-serial transmitter. It recovers aligned
//  8b/10b symbols from the serial stream in the PCIe/USB PHY datapath.
//  Bits arrive LSB first, one per CLOCK. The block hunts for K28.5 commas to find the
//  symbol boundary, then delivers one aligned 10-bit symbol every 10 clocks to the decoder.
// PARAMETERS
//  COMMA_P     10'h17C  K28.5, RD- (abcdei fghj = 001111 1010; bit a = bit 0)
//  COMMA_N     10'h283  K28.5, RD+ (110000 0101)
//  LOCK_COUNT  3        consecutive on-boundary commas needed to lock; legal range >= 2
//  LOSS_COUNT  4        cumulative off-boundary commas in LOCKED before lock is dropped; >= 1
// PORTS
//  CLOCK      in   1   bit clock; all logic on posedge
//  RESET_L    in   1   asynchronous reset, active low
//  IS         in   1   serial data in, sampled on posedge
//  OP         out  10  aligned symbol; bit 0 = first received bit
//  VALID      out  1   1-cycle pulse: OP holds a new aligned symbol
//  COMMA_DET  out  1   1-cycle pulse, coincident with VALID, when OP is COMMA_P or COMMA_N
//  ALIGNED    out  1   high while state is LOCKED
// BEHAVIOUR
//  Reset values (RESET_L low, async)
//   - sr=0, ph=0, good=0, miss=0, state=HUNT.
//   - OP=0, VALID=0, COMMA_DET=0, ALIGNED=0.
//   - Reset mid-symbol discards partial data; hunting restarts from scratch.
//  Shift register
//   - Every posedge: sr <= {IS, sr[9:1]}.
//   - comma = (sr==COMMA_P) | (sr==COMMA_N); combinational, evaluated on the current sr.
//  Phase counter
//   - ph is 4 bits and runs 0..9, wrapping 9->0. at_bnd = (ph==0).
//   - ph is reloaded to 1 on every comma accept (the accepting sr counts as phase 0).
//  FSM (all transitions on posedge)
//   HUNT
//    - comma: ph<=1, good<=1, ->CHECK.
//    - otherwise: remain in HUNT; ph is don't-care.
//   CHECK
//    - at_bnd & comma: if good+1==LOCK_COUNT -> LOCKED, miss<=0; else good<=good+1.
//    - !at_bnd & comma: re-phase; ph<=1, good<=1, stay in CHECK.
//    - at_bnd & !comma: no effect (data between commas is allowed).
//   LOCKED
//    - at_bnd & comma: miss<=0.
//    - !at_bnd & comma: miss<=miss+1; if miss+1==LOSS_COUNT -> HUNT, good<=0, miss<=0.
//      That misplaced comma is not used to re-phase.
//    - ph never reloads while in LOCKED.
//  Outputs (all registered)
//   - VALID<=1 and OP<=sr on any edge where at_bnd and either (state==LOCKED) or
//     (state==CHECK and the edge enters LOCKED). The locking comma is therefore delivered.
//   - If an off-boundary comma and a boundary coincide, the boundary wins: at_bnd excludes
//     the off-boundary case.
//   - COMMA_DET <= VALID condition & comma. OP holds its value between VALID pulses.
//   - ALIGNED <= (next state==LOCKED); it rises on the same edge as the locking VALID.
//  Latency
//   - Last bit of a symbol sampled at edge k -> sr complete after k -> OP/VALID after edge k+1.
//   - Symbol rate: exactly one VALID per 10 clocks while LOCKED; never two VALIDs < 10 apart.
//  Width rules
//   - good and miss saturate at their thresholds; they never wrap.
//   - ph must never exceed 9.
// TESTING
//  (Bench drives IS on negedge, LSB first.)
//  T1 Lock: 17C,283,17C,then 2A5 -> ALIGNED, VALID, COMMA_DET rise 1 clk after 3rd comma's
//     last bit, OP=17C; 10 clks later VALID with OP=2A5, COMMA_DET=0.
//  T2 Arbitrary offset: 3 junk bits (1,0,1), then T1 stream -> identical OP sequence;
//     VALID pulses shifted 3 clks.
//  T3 Re-phase in CHECK: 17C, 4 filler bits, 283,17C,283 -> the 2nd comma restarts good;
//     lock occurs on the 4th comma with OP=283.
//  T4 Loss: locked on 17C/283 data, then insert 4 commas each shifted by 5 bits ->
//     ALIGNED falls 1 clk after the 4th; VALID stops.
//  T5 Miss reset: locked, 3 misplaced commas, 1 aligned comma, 3 misplaced -> ALIGNED stays 1.
//  T6 Reset mid-symbol: pull RESET_L low after 6 bits of a locked symbol -> all outputs 0
//     immediately; after release, relock needs LOCK_COUNT fresh commas.

Source files
------------

// File: rtl/serial_symbol_aligner.sv
// rtl/serial_symbol_aligner.sv - hunts K28.5 commas in an LSB-first serial stream and emits aligned 10-bit symbols
module serial_symbol_aligner #(
  parameter logic [9:0] COMMA_P    = 10'h17C,
  parameter logic [9:0] COMMA_N    = 10'h283,
  parameter int         LOCK_COUNT = 3,
  parameter int         LOSS_COUNT = 4
) (
  input  logic       CLOCK,
  input  logic       RESET_L,
  input  logic       IS,
  output logic [9:0] OP,
  output logic       VALID,
  output logic       COMMA_DET,
  output logic       ALIGNED
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);
  // Counters stop one short of their threshold; the threshold itself is the transition.
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_COUNT - 1);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [9:0]    sr;
  logic [3:0]    ph;
  logic [GW-1:0] good, good_nxt;
  logic [MW-1:0] miss, miss_nxt;
  logic [1:0]    state, state_nxt;
  logic          reload;
  logic          comma;
  logic          at_bnd;
  logic          emit;

  assign comma  = (sr == COMMA_P) || (sr == COMMA_N);
  assign at_bnd = (ph == 4'd0);

  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    miss_nxt  = miss;
    reload    = 1'b0;
    case (state)
      HUNT: begin
        if (comma) begin
          reload    = 1'b1;
          good_nxt  = GW'(1);
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (comma) begin
          if (!at_bnd) begin
            reload   = 1'b1;
            good_nxt = GW'(1);
          end else if (good == GOOD_LAST) begin
            state_nxt = LOCKED;
            miss_nxt  = '0;
          end else begin
            good_nxt = good + GW'(1);
          end
        end
      end
      LOCKED: begin
        // A misplaced comma while locked only counts against the lock; it never re-phases.
        if (comma) begin
          if (at_bnd) begin
            miss_nxt = '0;
          end else if (miss == MISS_LAST) begin
            state_nxt = HUNT;
            good_nxt  = '0;
            miss_nxt  = '0;
          end else begin
            miss_nxt = miss + MW'(1);
          end
        end
      end
      default: begin
        state_nxt = HUNT;
        good_nxt  = '0;
        miss_nxt  = '0;
      end
    endcase
  end

  assign emit = at_bnd && ((state == LOCKED) || ((state == CHECK) && (state_nxt == LOCKED)));

  always_ff @(posedge CLOCK or negedge RESET_L) begin
    if (!RESET_L) begin
      sr        <= '0;
      ph        <= '0;
      good      <= '0;
      miss      <= '0;
      state     <= HUNT;
      OP        <= '0;
      VALID     <= 1'b0;
      COMMA_DET <= 1'b0;
      ALIGNED   <= 1'b0;
    end else begin
      sr <= {IS, sr[9:1]};
      if (reload) begin
        ph <= 4'd1;
      end else if (ph >= 4'd9) begin
        ph <= 4'd0;
      end else begin
        ph <= ph + 4'd1;
      end
      good      <= good_nxt;
      miss      <= miss_nxt;
      state     <= state_nxt;
      VALID     <= emit;
      COMMA_DET <= emit && comma;
      if (emit) begin
        OP <= sr;
      end
      ALIGNED <= (state_nxt == LOCKED);
    end
  end

endmodule

// File: tb/tb_serial_symbol_aligner.sv
// tb/tb_serial_symbol_aligner.sv - vector table, corner sequences and a random stream against a reference model
module tb_serial_symbol_aligner;

  localparam int         LOCK_COUNT = 3;
  localparam int         LOSS_COUNT = 4;
  localparam logic [9:0] CP   = 10'h17C;
  localparam logic [9:0] CN   = 10'h283;
  localparam logic [9:0] D1   = 10'h2A5;
  localparam logic [9:0] FILL = 10'h00A;

  logic       CLOCK   = 1'b0;
  logic       RESET_L = 1'b0;
  logic       IS      = 1'b0;
  logic [9:0] OP;
  logic       VALID, COMMA_DET, ALIGNED;

  int checks = 0;
  int errors = 0;

  serial_symbol_aligner dut (
    .CLOCK(CLOCK), .RESET_L(RESET_L), .IS(IS),
    .OP(OP), .VALID(VALID), .COMMA_DET(COMMA_DET), .ALIGNED(ALIGNED)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference: boundaries are every 10th edge counted from the last accepted comma.
  int m_win, m_t, m_anchor, m_good, m_miss, m_state, m_op;
  bit m_valid, m_cd, m_aligned;

  task automatic m_reset();
    m_win = 0; m_t = 0; m_anchor = 0; m_good = 0; m_miss = 0; m_state = 0;
    m_op = 0; m_valid = 0; m_cd = 0; m_aligned = 0;
  endtask

  task automatic m_step(input bit b);
    bit is_comma, bnd, em;
    is_comma = (m_win == 'h17C) || (m_win == 'h283);
    bnd      = ((m_t - m_anchor) % 10) == 0;
    em       = 0;
    if (m_state == 0) begin
      if (is_comma) begin m_anchor = m_t; m_good = 1; m_state = 1; end
    end else if (m_state == 1) begin
      if (is_comma && bnd) begin
        if (m_good + 1 == LOCK_COUNT) begin m_state = 2; m_miss = 0; em = 1; end
        else m_good++;
      end else if (is_comma) begin
        m_anchor = m_t; m_good = 1;
      end
    end else begin
      if (bnd) begin
        em = 1;
        if (is_comma) m_miss = 0;
      end else if (is_comma) begin
        m_miss++;
        if (m_miss == LOSS_COUNT) begin m_state = 0; m_good = 0; m_miss = 0; end
      end
    end
    m_valid = em;
    m_cd    = em && is_comma;
    if (em) m_op = m_win;
    m_aligned = (m_state == 2);
    m_win = (m_win >> 1) + (b ? 512 : 0);
    m_t++;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge CLOCK or negedge RESET_L);
      if (!RESET_L) m_reset();
      else m_step(IS);
    end
  end

  initial begin
    forever begin
      @(negedge CLOCK);
      checks++;
      if ({VALID, COMMA_DET, ALIGNED, OP} !== {m_valid, m_cd, m_aligned, m_op[9:0]}) begin
        errors++;
        $display("FAIL model_cycle t=%0t: got v=%0b cd=%0b al=%0b op=%h, expected v=%0b cd=%0b al=%0b op=%h",
                 $time, VALID, COMMA_DET, ALIGNED, OP, m_valid, m_cd, m_aligned, m_op[9:0]);
      end
    end
  end

  logic       lv [0:255];
  logic       lcd[0:255];
  logic       la [0:255];
  logic [9:0] lop[0:255];
  int         ln = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge CLOCK);
    if (ln < 256) begin
      lv[ln] = VALID; lcd[ln] = COMMA_DET; la[ln] = ALIGNED; lop[ln] = OP;
    end
    ln++;
    IS = b;
  endtask

  task automatic send_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) drive_bit(s[i]);
  endtask

  task automatic send_bits(input int n, input logic [9:0] v);
    for (int i = 0; i < n; i++) drive_bit(v[i]);
  endtask

  task automatic do_reset();
    RESET_L = 1'b0;
    IS      = 1'b0;
    repeat (2) @(negedge CLOCK);
    RESET_L = 1'b1;
    ln      = 0;
  endtask

  function automatic int first_valid(input int from);
    for (int i = from; i < ln && i < 256; i++) if (lv[i]) return i;
    return -1;
  endfunction

  function automatic int count_ones_al(input int from, input int upto);
    int n = 0;
    for (int i = from; i < upto && i < 256; i++) if (la[i]) n++;
    return n;
  endfunction

  function automatic int count_valid(input int from, input int upto);
    int n = 0;
    for (int i = from; i < upto && i < 256; i++) if (lv[i]) n++;
    return n;
  endfunction

  typedef struct {
    int          pre_n;
    logic [9:0]  pre_bits;
    int          mid_n;
    logic [9:0]  mid_bits;
    logic [39:0] syms;
    int          first;
    logic [9:0]  op;
    logic        cd;
    int          next_at;
    logic [9:0]  next_op;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int f, n;
    logic [9:0] rs;
    bit pol;

    vecs[0] = '{0, 10'h000, 0, 10'h000, {D1, CP, CN, CP}, 31, CP, 1'b1, 41, D1};
    vecs[1] = '{3, 10'h005, 0, 10'h000, {D1, CP, CN, CP}, 34, CP, 1'b1, 44, D1};
    vecs[2] = '{0, 10'h000, 4, 10'h000, {CN, CP, CN, CP}, 45, CN, 1'b1, -1, 10'h000};
    vecs[3] = '{0, 10'h000, 0, 10'h000, {D1, D1, CN, CP}, -1, 10'h000, 1'b0, -1, 10'h000};
    vecs[4] = '{0, 10'h000, 0, 10'h000, {D1, CN, CP, CN}, 31, CN, 1'b1, 41, D1};

    #7;
    check("reset_outputs", {VALID, COMMA_DET, ALIGNED}, 0);
    check("reset_op", OP, 0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      send_bits(vecs[v].pre_n, vecs[v].pre_bits);
      send_sym(vecs[v].syms[9:0]);
      send_bits(vecs[v].mid_n, vecs[v].mid_bits);
      send_sym(vecs[v].syms[19:10]);
      send_sym(vecs[v].syms[29:20]);
      send_sym(vecs[v].syms[39:30]);
      send_bits(4, 10'h000);
      f = first_valid(0);
      check($sformatf("vec%0d first_valid", v), f, vecs[v].first);
      if (vecs[v].first < 0) begin
        check($sformatf("vec%0d never_aligned", v), count_ones_al(0, ln), 0);
      end else if (f == vecs[v].first) begin
        check($sformatf("vec%0d lock_op", v), lop[f], vecs[v].op);
        check($sformatf("vec%0d lock_cd", v), lcd[f], vecs[v].cd);
        check($sformatf("vec%0d aligned_rise", v), {la[f-1], la[f]}, 2'b01);
        if (vecs[v].next_at >= 0) begin
          check($sformatf("vec%0d gap_valids", v), count_valid(f + 1, vecs[v].next_at), 0);
          check($sformatf("vec%0d next_valid", v), lv[vecs[v].next_at], 1);
          check($sformatf("vec%0d next_op", v), lop[vecs[v].next_at], vecs[v].next_op);
          check($sformatf("vec%0d next_cd", v), lcd[vecs[v].next_at], 0);
        end
      end
    end

    // Loss of lock after LOSS_COUNT misplaced commas.
    do_reset();
    send_sym(CP); send_sym(CN); send_sym(CP); send_sym(CN);
    send_bits(5, FILL);
    send_sym(CN); send_sym(CP); send_sym(CN); send_sym(CP);
    send_bits(2, 10'h000);
    send_bits(10, 10'h000); send_bits(10, 10'h000);
    check("loss locked_before", la[44], 1);
    check("loss aligned_edge", {la[85], la[86]}, 2'b10);
    check("loss no_valid_after", count_valid(86, ln), 0);

    // An aligned comma clears the miss count.
    do_reset();
    send_sym(CP); send_sym(CN); send_sym(CP); send_sym(CN);
    send_bits(5, FILL);
    send_sym(CN); send_sym(CP); send_sym(CN);
    send_bits(5, FILL);
    send_sym(CP);
    send_bits(5, FILL);
    send_sym(CN); send_sym(CP); send_sym(CN);
    send_bits(12, 10'h000);
    check("missreset aligned_comma", {lv[91], lcd[91], lop[91]}, {2'b11, CP});
    check("missreset stays_aligned", count_ones_al(31, ln), ln - 31);

    // Reset in the middle of a locked symbol.
    do_reset();
    send_sym(CP); send_sym(CN); send_sym(CP); send_sym(CN);
    send_bits(6, D1);
    check("midreset locked_before", ALIGNED, 1);
    #2 RESET_L = 1'b0;
    #1;
    check("midreset outputs", {VALID, COMMA_DET, ALIGNED}, 0);
    check("midreset op", OP, 0);
    @(negedge CLOCK);
    RESET_L = 1'b1;
    ln = 0;
    send_sym(CP); send_sym(CN); send_sym(CP);
    send_bits(2, 10'h000);
    check("relock not_early", count_ones_al(0, 31), 0);
    check("relock aligned", {lv[31], la[31], lop[31]}, {2'b11, CP});

    // Random stream of commas, arbitrary symbols and odd-length slips.
    do_reset();
    pol = 0;
    for (int k = 0; k < 220; k++) begin
      n = $urandom_range(0, 9);
      if (n < 5) begin
        send_sym(pol ? CN : CP);
        pol = !pol;
      end else if (n < 8) begin
        rs = 10'($urandom_range(0, 1023));
        send_sym(rs);
      end else begin
        rs = 10'($urandom_range(0, 1023));
        send_bits($urandom_range(1, 9), rs);
      end
    end
    send_bits(4, 10'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
